// File: rtl/keccak_rho_rotator.sv
// Keccak rho-step engine working on serial 25-bit slices.
// A 5x5xLANE_W state is loaded one slice per accepted cycle (z = 0 first),
// held in 25 lane registers, then streamed back out slice by slice with each
// lane rotated by its rho offset (reduced mod LANE_W).
// Optional feature macro: ROT_INV_EN -- when defined, 'inv' is latched at start
// and selects the inverse rotation (rotate right by r_i) for that state.
module keccak_rho_rotator #(
  parameter int unsigned LANE_W = 64,
  localparam int unsigned CNT_W = $clog2(LANE_W)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [24:0] in,
  input  logic        inValid,
  output logic        putInput,
  output logic [24:0] out,
  output logic        outReady,
  input  logic        outAck,
  output logic        ready,
  input  logic        inv
);

  typedef enum logic [1:0] {StIdle, StLoad, StUnload} state_e;

  // Rho offsets indexed by lane number x+5y; only the low CNT_W bits are used.
  localparam logic [5:0] RHO [25] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  localparam logic [CNT_W-1:0] ZLast = CNT_W'(LANE_W - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   zcnt_q;
  logic [LANE_W-1:0]  lane_q [25];
  logic [CNT_W-1:0]   rd_idx [25];

`ifdef ROT_INV_EN
  logic mode_q;
`else
  logic unused_inv;
  assign unused_inv = inv;
`endif

  // Control FSM: state, slice counter and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      zcnt_q   <= '0;
      ready    <= 1'b1;
      putInput <= 1'b0;
      outReady <= 1'b0;
`ifdef ROT_INV_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StLoad;
            zcnt_q   <= '0;
            ready    <= 1'b0;
            putInput <= 1'b1;
`ifdef ROT_INV_EN
            mode_q   <= inv;
`endif
          end
        end
        StLoad: begin
          if (inValid) begin
            if (zcnt_q == ZLast) begin
              state_q  <= StUnload;
              zcnt_q   <= '0;
              putInput <= 1'b0;
              outReady <= 1'b1;
            end else begin
              zcnt_q <= zcnt_q + CNT_W'(1);
            end
          end
        end
        StUnload: begin
          if (outAck) begin
            if (zcnt_q == ZLast) begin
              state_q  <= StIdle;
              zcnt_q   <= '0;
              outReady <= 1'b0;
              ready    <= 1'b1;
            end else begin
              zcnt_q <= zcnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          zcnt_q   <= '0;
          ready    <= 1'b1;
          putInput <= 1'b0;
          outReady <= 1'b0;
        end
      endcase
    end
  end

  // Lane storage: each accepted slice fills bit zcnt of every lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 25; i++) begin
        lane_q[i] <= '0;
      end
    end else if (state_q == StLoad && inValid) begin
      for (int i = 0; i < 25; i++) begin
        lane_q[i][zcnt_q] <= in[i];
      end
    end
  end

  // Per-lane read index: z - r (forward) or z + r (inverse), wrapping mod LANE_W.
  always_comb begin
    for (int i = 0; i < 25; i++) begin
      rd_idx[i] = '0;
    end
    for (int i = 0; i < 25; i++) begin
`ifdef ROT_INV_EN
      if (mode_q) begin
        rd_idx[i] = zcnt_q + RHO[i][CNT_W-1:0];
      end else begin
        rd_idx[i] = zcnt_q - RHO[i][CNT_W-1:0];
      end
`else
      rd_idx[i] = zcnt_q - RHO[i][CNT_W-1:0];
`endif
    end
  end

  // Output slice, forced to zero whenever no slice is being offered.
  always_comb begin
    out = '0;
    if (outReady) begin
      for (int i = 0; i < 25; i++) begin
        out[i] = lane_q[i][rd_idx[i]];
      end
    end
  end

endmodule
